// File: rtl/intmul_iter.sv
// Iterative unsigned multiplier: A is consumed LIMB bits per cycle against the full B,
// with valid/ready handshakes on both sides and a tag carried alongside each operation.
module intmul_iter #(
  parameter int unsigned LOGA = 32,
  parameter int unsigned LOGB = 32,
  parameter int unsigned LIMB = 16,
  parameter int unsigned LOGT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LOGA-1:0]      A,
  input  logic [LOGB-1:0]      B,
  input  logic [LOGT-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOGA+LOGB-1:0] C,
  output logic [LOGT-1:0]      out_tag,
  output logic                 busy
);
  localparam int unsigned NPASS = (LOGA + LIMB - 1) / LIMB;
  localparam int unsigned CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int unsigned AE    = NPASS * LIMB;
  localparam int unsigned CWID  = LOGA + LOGB;
  localparam int unsigned PW    = LIMB + LOGB;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [AE-1:0]   a_sh;
  logic [LOGB-1:0] b_q;
  logic [LOGT-1:0] tag_q;
  logic [CWID-1:0] acc;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   pp;
  logic [31:0]     sh;
  logic            accept;
  logic            last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CW'(NPASS - 1));
  // The latched A shifts right each pass, so the current digit is always its low LIMB bits.
  assign pp     = PW'(a_sh[LIMB-1:0]) * PW'(b_q);
  assign sh     = 32'(cnt) * LIMB;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = ~rst;
      BUSY: busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_q   <= '0;
      tag_q <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= AE'(A);
      b_q   <= B;
      tag_q <= in_tag;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == BUSY) begin
      acc  <= acc + (CWID'(pp) << sh);
      a_sh <= a_sh >> LIMB;
      cnt  <= cnt + 1'b1;
    end
  end

  // The accumulator doubles as the result register; it only changes in BUSY or on accept.
  assign C       = acc;
  assign out_tag = tag_q;
endmodule

// File: tb/tb_intmul_iter.sv
// Self-checking bench for intmul_iter: three configurations (NPASS = 2, 3 padded, 1),
// directed handshake/reset steps followed by randomized traffic against a product model.
module tb_intmul_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [33:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  tag_in;
  logic        iv  [3];
  logic        ir  [3];
  logic        ov  [3];
  logic        orr [3];
  logic        bz  [3];
  logic [3:0]  ot  [3];
  logic [63:0] c0, c2;
  logic [65:0] c1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  intmul_iter #(.LOGA(32), .LOGB(32), .LIMB(16), .LOGT(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(a_in[31:0]), .B(b_in),
    .in_tag(tag_in), .out_valid(ov[0]), .out_ready(orr[0]), .C(c0), .out_tag(ot[0]), .busy(bz[0]));

  intmul_iter #(.LOGA(34), .LOGB(32), .LIMB(16), .LOGT(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(a_in), .B(b_in),
    .in_tag(tag_in), .out_valid(ov[1]), .out_ready(orr[1]), .C(c1), .out_tag(ot[1]), .busy(bz[1]));

  intmul_iter #(.LOGA(32), .LOGB(32), .LIMB(32), .LOGT(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .A(a_in[31:0]), .B(b_in),
    .in_tag(tag_in), .out_valid(ov[2]), .out_ready(orr[2]), .C(c2), .out_tag(ot[2]), .busy(bz[2]));

  function automatic logic [65:0] get_c(input int d);
    case (d)
      0:       return {2'b00, c0};
      1:       return c1;
      default: return {2'b00, c2};
    endcase
  endfunction

  function automatic int npass(input int d);
    case (d)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  // Golden product: plain arithmetic on A truncated to the instance's operand width.
  function automatic logic [65:0] ref_mul(input int d, input logic [33:0] a, input logic [31:0] b);
    logic [65:0] aa;
    aa = (d == 1) ? {32'b0, a} : {34'b0, a[31:0]};
    return aa * {34'b0, b};
  endfunction

  task automatic check(input string name, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Result becomes visible NPASS+1 sample points after the one where the accept was driven.
  task automatic run_ops(input int d, input int nops, input int rdy_pct, input bit seq_tag);
    logic [65:0] exp_q[$];
    logic [3:0]  tag_q[$];
    int          cyc_q[$];
    int          sent, got, budget;
    bit          seen, hold, accepted;
    logic [65:0] hold_c;
    logic [3:0]  hold_t;
    logic [33:0] a;
    logic [31:0] b;
    sent   = 0;
    got    = 0;
    seen   = 1'b0;
    hold   = 1'b0;
    hold_c = '0;
    hold_t = '0;
    budget = nops * (npass(d) + 1) * 8 + 100;
    iv[d]  = 1'b0;
    while (got < nops && budget > 0) begin
      budget--;
      accepted = 1'b0;
      if (!iv[d] && sent < nops) begin
        a = {2'($urandom), 32'($urandom)};
        b = $urandom;
        case ($urandom_range(0, 7))
          0:       a = '0;
          1:       b = '0;
          default: ;
        endcase
        a_in   = a;
        b_in   = b;
        tag_in = seq_tag ? 4'(sent + 1) : 4'($urandom);
        iv[d]  = 1'b1;
      end
      orr[d] = ($urandom_range(1, 100) <= rdy_pct);
      #1;
      if (hold) begin
        check("hold_valid", 66'(ov[d]), 66'(1));
        check("hold_c", get_c(d), hold_c);
        check("hold_tag", 66'(ot[d]), 66'(hold_t));
      end
      if (exp_q.size() == 0) check("spurious_valid", 66'(ov[d]), 66'(0));
      else if (ov[d] && !seen) begin
        check("latency", 66'(cyc - cyc_q[0]), 66'(npass(d) + 1));
        seen = 1'b1;
      end
      hold   = ov[d] && !orr[d];
      hold_c = get_c(d);
      hold_t = ot[d];
      if (ov[d] && orr[d] && exp_q.size() > 0) begin
        check("rand_c", get_c(d), exp_q.pop_front());
        check("rand_tag", 66'(ot[d]), 66'(tag_q.pop_front()));
        void'(cyc_q.pop_front());
        got++;
        seen = 1'b0;
      end
      if (iv[d] && ir[d]) begin
        exp_q.push_back(ref_mul(d, a_in, b_in));
        tag_q.push_back(tag_in);
        cyc_q.push_back(cyc);
        sent++;
        accepted = 1'b1;
      end
      tick();
      if (accepted) iv[d] = 1'b0;
    end
    if (got < nops) check("timeout_ops", 66'(got), 66'(nops));
    iv[d]  = 1'b0;
    orr[d] = 1'b1;
    tick();
    orr[d] = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    a_in   = '0;
    b_in   = '0;
    tag_in = '0;
    for (int i = 0; i < 3; i++) begin
      iv[i]  = 1'b0;
      orr[i] = 1'b0;
    end
    repeat (3) tick();
    check("rst_in_ready", 66'(ir[0]), 66'(0));
    check("rst_out_valid", 66'(ov[0]), 66'(0));
    check("rst_c", get_c(0), 66'(0));
    check("rst_tag", 66'(ot[0]), 66'(0));
    check("rst_busy", 66'(bz[0]), 66'(0));
    rst = 1'b0;
    #1;
    check("idle_in_ready", 66'(ir[0]), 66'(1));

    // Single operation, NPASS=2
    a_in = 34'h0FFFFFFFF; b_in = 32'hFFFFFFFF; tag_in = 4'd5; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0; a_in = '0; b_in = '0; tag_in = '0;
    check("op1_busy0", 66'(bz[0]), 66'(1));
    check("op1_nvalid0", 66'(ov[0]), 66'(0));
    tick();
    check("op1_busy1", 66'(bz[0]), 66'(1));
    check("op1_nvalid1", 66'(ov[0]), 66'(0));
    tick();
    check("op1_valid", 66'(ov[0]), 66'(1));
    check("op1_c", get_c(0), 66'h0FFFFFFFE00000001);
    check("op1_tag", 66'(ot[0]), 66'(5));
    check("op1_busy_done", 66'(bz[0]), 66'(0));

    // Backpressure: a pending operand must wait until out_ready rises
    a_in = 34'd3; b_in = 32'd7; tag_in = 4'd9; iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", 66'(ov[0]), 66'(1));
      check("bp_c", get_c(0), 66'h0FFFFFFFE00000001);
      check("bp_tag", 66'(ot[0]), 66'(5));
      check("bp_in_ready", 66'(ir[0]), 66'(0));
      tick();
    end
    orr[0] = 1'b1;
    #1;
    check("bp_release_ready", 66'(ir[0]), 66'(1));
    tick();
    iv[0] = 1'b0; orr[0] = 1'b0;
    check("bp_accept_busy", 66'(bz[0]), 66'(1));
    check("bp_accept_nvalid", 66'(ov[0]), 66'(0));
    tick();
    tick();
    check("op2_valid", 66'(ov[0]), 66'(1));
    check("op2_c", get_c(0), 66'd21);
    check("op2_tag", 66'(ot[0]), 66'(9));
    orr[0] = 1'b1;
    tick();
    orr[0] = 1'b0;
    check("op2_drain_idle", 66'(ov[0]), 66'(0));
    check("op2_idle_ready", 66'(ir[0]), 66'(1));

    // Reset in the second BUSY cycle drops the operation
    a_in = 34'h0FFFFFFFF; b_in = 32'hFFFFFFFF; tag_in = 4'd7; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 66'(ov[0]), 66'(0));
    check("mid_rst_c", get_c(0), 66'(0));
    check("mid_rst_busy", 66'(bz[0]), 66'(0));
    check("mid_rst_in_ready", 66'(ir[0]), 66'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 66'(ir[0]), 66'(1));
    orr[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dropped_no_output", 66'(ov[0]), 66'(0));
    end
    orr[0] = 1'b0;

    // Zero-extended A with NPASS=3
    a_in = 34'h200000001; b_in = 32'd3; tag_in = 4'hA; iv[1] = 1'b1;
    tick();
    iv[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pad_busy", 66'(bz[1]), 66'(1));
      tick();
    end
    check("pad_valid", 66'(ov[1]), 66'(1));
    check("pad_c", get_c(1), 66'h600000003);
    check("pad_tag", 66'(ot[1]), 66'hA);
    orr[1] = 1'b1;
    tick();
    orr[1] = 1'b0;

    // Single-pass configuration
    a_in = 34'h0FFFFFFFF; b_in = 32'hFFFFFFFF; tag_in = 4'd3; iv[2] = 1'b1;
    tick();
    iv[2] = 1'b0;
    check("np1_busy", 66'(bz[2]), 66'(1));
    tick();
    check("np1_valid", 66'(ov[2]), 66'(1));
    check("np1_c", get_c(2), 66'h0FFFFFFFE00000001);
    check("np1_tag", 66'(ot[2]), 66'(3));
    orr[2] = 1'b1;
    tick();
    orr[2] = 1'b0;

    // Streaming with out_ready high, then randomized traffic
    run_ops(0, 3, 100, 1'b1);
    run_ops(0, 6000, 60, 1'b0);
    run_ops(1, 2000, 50, 1'b0);
    run_ops(2, 2000, 70, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
